// File: rtl/contador_param.sv
// WIDTH-bit up / down / down-by-STEP counter with parallel load, registered
// wrap flag (carry or borrow), load pulse and saturating wrap-event counter.
module contador_param #(
    parameter int WIDTH  = 4,
    parameter int STEP   = 3,
    parameter int WRAP_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENB,
    input  logic [1:0]        MODO,
    input  logic [WIDTH-1:0]  D,
    output logic [WIDTH-1:0]  Q,
    output logic              RCO,
    output logic [WRAP_W-1:0] WRAPS,
    output logic              LOADED
);

    localparam logic [1:0] MODO_UP   = 2'b00;
    localparam logic [1:0] MODO_DOWN = 2'b01;
    localparam logic [1:0] MODO_STEP = 2'b10;
    localparam logic [1:0] MODO_LOAD = 2'b11;

    localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0]  q_q, q_d;
    logic              rco_q, rco_d;
    logic              loaded_q, loaded_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;

    logic [WIDTH:0] inc_x, dec_x, sub_x;

    // The extra MSB of each result is the carry (up) or borrow (down) out.
    assign inc_x = {1'b0, q_q} + ONE_X;
    assign dec_x = {1'b0, q_q} - ONE_X;
    assign sub_x = {1'b0, q_q} - STEP_X;

    always_comb begin
        q_d      = q_q;
        rco_d    = 1'b0;
        loaded_d = 1'b0;
        wraps_d  = wraps_q;
        if (ENB) begin
            case (MODO)
                MODO_UP: begin
                    q_d   = inc_x[WIDTH-1:0];
                    rco_d = inc_x[WIDTH];
                end
                MODO_DOWN: begin
                    q_d   = dec_x[WIDTH-1:0];
                    rco_d = dec_x[WIDTH];
                end
                MODO_STEP: begin
                    q_d   = sub_x[WIDTH-1:0];
                    rco_d = sub_x[WIDTH];
                end
                MODO_LOAD: begin
                    q_d      = D;
                    loaded_d = 1'b1;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
        // Saturate rather than roll over so a monitor never sees a small count
        // after a long run.
        if (rco_d && (wraps_q != {WRAP_W{1'b1}})) begin
            wraps_d = wraps_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            q_q      <= '0;
            rco_q    <= 1'b0;
            loaded_q <= 1'b0;
            wraps_q  <= '0;
        end else begin
            q_q      <= q_d;
            rco_q    <= rco_d;
            loaded_q <= loaded_d;
            wraps_q  <= wraps_d;
        end
    end

    assign Q      = q_q;
    assign RCO    = rco_q;
    assign LOADED = loaded_q;
    assign WRAPS  = wraps_q;

endmodule

// File: tb/tb_contador_param.sv
// Bench for contador_param: directed plan plus random stimulus, checked each
// cycle against an integer model; a WRAP_W=2 copy exercises saturation.
module tb_contador_param;

    localparam int W    = 4;
    localparam int M    = 16;
    localparam int STP  = 3;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       enb = 1'b0;
    logic [1:0] modo = 2'b00;
    logic [3:0] d = 4'h0;

    logic [3:0] q_a, q_b;
    logic       rco_a, rco_b, ld_a, ld_b;
    logic [7:0] wr_a;
    logic [1:0] wr_b;

    int checks = 0;
    int errors = 0;

    int m_q = 0, m_rco = 0, m_ld = 0, m_wr8 = 0, m_wr2 = 0;
    bit m_valid = 0;

    always #5 CLK = ~CLK;

    contador_param #(.WIDTH(W), .STEP(STP), .WRAP_W(8)) u_dut (
        .CLK(CLK), .RESET(rst), .ENB(enb), .MODO(modo), .D(d),
        .Q(q_a), .RCO(rco_a), .WRAPS(wr_a), .LOADED(ld_a)
    );

    contador_param #(.WIDTH(W), .STEP(STP), .WRAP_W(2)) u_sat (
        .CLK(CLK), .RESET(rst), .ENB(enb), .MODO(modo), .D(d),
        .Q(q_b), .RCO(rco_b), .WRAPS(wr_b), .LOADED(ld_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: plain modular integer arithmetic on the old count.
    always @(posedge CLK) begin
        if (rst) begin
            m_q = 0; m_rco = 0; m_ld = 0; m_wr8 = 0; m_wr2 = 0;
            m_valid = 1;
        end else if (!enb) begin
            m_rco = 0; m_ld = 0;
        end else begin
            m_ld = 0;
            case (modo)
                2'd0: begin m_rco = (m_q == M-1); m_q = (m_q + 1) % M; end
                2'd1: begin m_rco = (m_q == 0);   m_q = (m_q + M - 1) % M; end
                2'd2: begin m_rco = (m_q < STP);  m_q = (m_q + M - STP) % M; end
                default: begin m_rco = 0; m_q = int'(d); m_ld = 1; end
            endcase
            if (m_rco) begin
                if (m_wr8 < 255) m_wr8++;
                if (m_wr2 < 3) m_wr2++;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("q", int'(q_a), m_q);
            chk("rco", int'(rco_a), m_rco);
            chk("loaded", int'(ld_a), m_ld);
            chk("wraps", int'(wr_a), m_wr8);
            chk("q_sat", int'(q_b), m_q);
            chk("rco_sat", int'(rco_b), m_rco);
            chk("wraps_sat", int'(wr_b), m_wr2);
        end
    end

    task automatic drive(input bit r, input bit e, input logic [1:0] m, input logic [3:0] dv);
        @(negedge CLK);
        rst = r; enb = e; modo = m; d = dv;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset with ENB=1, MODO=00, then hold
        drive(1, 1, 2'd0, 4'h0);
        drive(1, 1, 2'd0, 4'h0);
        chk("lit_rst_q", int'(q_a), 0);
        chk("lit_rst_rco", int'(rco_a), 0);
        chk("lit_rst_wraps", int'(wr_a), 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 2'd0, 4'h7);
            chk("lit_hold_q", int'(q_a), 0);
            chk("lit_hold_rco", int'(rco_a), 0);
        end

        // Up wrap
        drive(0, 1, 2'd3, 4'hE);
        chk("lit_load_q", int'(q_a), 14);
        chk("lit_load_pulse", int'(ld_a), 1);
        drive(0, 1, 2'd0, 4'h0);
        chk("lit_up1_q", int'(q_a), 15);
        chk("lit_up1_rco", int'(rco_a), 0);
        chk("lit_up1_loaded", int'(ld_a), 0);
        drive(0, 1, 2'd0, 4'h0);
        chk("lit_up2_q", int'(q_a), 0);
        chk("lit_up2_rco", int'(rco_a), 1);
        chk("lit_up2_wraps", int'(wr_a), 1);
        drive(0, 1, 2'd0, 4'h0);
        chk("lit_up3_q", int'(q_a), 1);
        chk("lit_up3_rco", int'(rco_a), 0);

        // Down-by-3 borrow and down borrow
        drive(0, 1, 2'd3, 4'h2);
        drive(0, 1, 2'd2, 4'h0);
        chk("lit_step_q", int'(q_a), 15);
        chk("lit_step_rco", int'(rco_a), 1);
        chk("lit_step_wraps", int'(wr_a), 2);
        drive(0, 1, 2'd2, 4'h0);
        chk("lit_step2_q", int'(q_a), 12);
        chk("lit_step2_rco", int'(rco_a), 0);
        drive(0, 1, 2'd3, 4'h0);
        drive(0, 1, 2'd1, 4'h0);
        chk("lit_down_q", int'(q_a), 15);
        chk("lit_down_rco", int'(rco_a), 1);
        chk("lit_down_wraps", int'(wr_a), 3);

        // Enable gating right after a wrap pulse
        drive(0, 1, 2'd0, 4'h0);
        chk("lit_gate_rco_hi", int'(rco_a), 1);
        drive(0, 0, 2'd0, 4'h0);
        chk("lit_gate_rco_lo", int'(rco_a), 0);
        chk("lit_gate_q", int'(q_a), 0);
        chk("lit_gate_wraps", int'(wr_a), 4);
        drive(0, 1, 2'd0, 4'h0);
        chk("lit_resume_q", int'(q_a), 1);

        // Mid-operation reset beats a load
        drive(0, 1, 2'd3, 4'h9);
        drive(1, 1, 2'd3, 4'h5);
        chk("lit_midrst_q", int'(q_a), 0);
        chk("lit_midrst_loaded", int'(ld_a), 0);
        chk("lit_midrst_wraps", int'(wr_a), 0);
        drive(0, 1, 2'd1, 4'h0);
        chk("lit_after_rst_q", int'(q_a), 15);

        // Saturation on the WRAP_W=2 copy
        drive(1, 0, 2'd0, 4'h0);
        for (int w = 1; w <= 6; w++) begin
            drive(0, 1, 2'd3, 4'hF);
            drive(0, 1, 2'd0, 4'h0);
            chk("lit_sat_rco", int'(rco_b), 1);
            chk("lit_sat_wraps", int'(wr_b), (w < 3) ? w : 3);
            chk("lit_wide_wraps", int'(wr_a), w);
        end

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end

        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
